mem_port_b_arbiter: RTL and testbench

//  Shares the memory stage's read-only port B (address_b / read_data_b) between two requesters:

---
 rtl/mem_port_b_arbiter.sv | 119 +++++++++++
 tb/tb_mem_port_b_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_b_arbiter.sv
// Arbiter for the memory stage's read-only port B: display has priority, debug is protected by a
// starvation guard, and returns are routed back to their owner through an in-order tag pipeline.
module mem_port_b_arbiter #(
  parameter int ADDR_W       = 17,
  parameter int DATA_W       = 24,
  parameter int READ_LATENCY = 2,
  parameter int SIN_BASE     = 90000,
  parameter int RAM_BASE     = 90300,
  parameter int STARVE_LIMIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_gnt,
  output logic              dbg_valid,
  output logic [DATA_W-1:0] dbg_data,
  output logic              dbg_err,
  output logic [ADDR_W-1:0] address_b,
  input  logic [DATA_W-1:0] read_data_b,
  output logic [1:0]        inflight
);

  localparam int DEPTH = READ_LATENCY + 1;
  localparam logic [ADDR_W-1:0] SIN_LO = ADDR_W'(SIN_BASE);
  localparam logic [ADDR_W-1:0] SIN_HI = ADDR_W'(RAM_BASE);
  localparam logic [7:0]        LIMIT  = 8'(STARVE_LIMIT);

  // owner: 0 = display, 1 = debug
  typedef struct packed {
    logic valid;
    logic owner;
    logic sin_hit;
  } tag_t;

  tag_t        tags [DEPTH];
  tag_t        ret_tag;
  logic [7:0]  streak;
  logic        accept;
  logic        sin_hit;

  // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
  // Grants are gated by rst so they drop the instant reset asserts, not at the next edge.
  always_comb begin
    disp_gnt  = 1'b0;
    dbg_gnt   = 1'b0;
    address_b = '0;
    if (!rst) begin
      if (disp_req && !(dbg_req && streak == LIMIT)) disp_gnt = 1'b1;
      else if (dbg_req)                              dbg_gnt  = 1'b1;
    end
    if (disp_gnt)     address_b = disp_addr;
    else if (dbg_gnt) address_b = dbg_addr;
  end

  assign accept  = disp_gnt | dbg_gnt;
  assign sin_hit = (address_b >= SIN_LO) && (address_b < SIN_HI);
  assign ret_tag = tags[READ_LATENCY-1];

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak <= '0;
    end else if (disp_gnt && dbg_req) begin
      if (streak != LIMIT) streak <= streak + 8'd1;
    end else begin
      streak <= '0;
    end
  end

  // NOTE: the tag pipeline is reset, unlike a data RAM, because its valid bits drive output pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) tags[i] <= '0;
    end else begin
      tags[0] <= '{valid: accept, owner: dbg_gnt, sin_hit: sin_hit};
      for (int i = 1; i < DEPTH; i++) tags[i] <= tags[i-1];
    end
  end

  // read_data_b holds the word for the tag now in stage READ_LATENCY-1; capture it for the owner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_valid <= 1'b0;
      disp_data  <= '0;
      dbg_valid  <= 1'b0;
      dbg_data   <= '0;
      dbg_err    <= 1'b0;
    end else begin
      disp_valid <= ret_tag.valid && !ret_tag.owner;
      dbg_valid  <= ret_tag.valid && ret_tag.owner;
      if (ret_tag.valid && !ret_tag.owner)
        disp_data <= ret_tag.sin_hit ? '0 : read_data_b;
      if (ret_tag.valid && ret_tag.owner) begin
        dbg_data <= ret_tag.sin_hit ? '0 : read_data_b;
        dbg_err  <= ret_tag.sin_hit;
      end
    end
  end

  // Tracks the popcount of tag valid bits: in at stage 0, out past the last stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      case ({accept, tags[DEPTH-1].valid})
        2'b10:   inflight <= inflight + 2'd1;
        2'b01:   inflight <= inflight - 2'd1;
        default: inflight <= inflight;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_b_arbiter.sv
// Scoreboard bench for mem_port_b_arbiter: a reference model predicts grants, inflight and
// returned words; a negedge monitor pops expected returns whenever a valid pulse appears.
module tb_mem_port_b_arbiter;

  localparam int AW    = 17;
  localparam int DW    = 24;
  localparam int RL    = 2;
  localparam int LIMIT = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          disp_req, dbg_req;
  logic [AW-1:0] disp_addr, dbg_addr;
  logic          disp_gnt, dbg_gnt, disp_valid, dbg_valid, dbg_err;
  logic [DW-1:0] disp_data, dbg_data;
  logic [AW-1:0] address_b;
  logic [DW-1:0] read_data_b;
  logic [1:0]    inflight;

  mem_port_b_arbiter dut (
    .clk(clk), .rst(rst),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
    .disp_valid(disp_valid), .disp_data(disp_data),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt),
    .dbg_valid(dbg_valid), .dbg_data(dbg_data), .dbg_err(dbg_err),
    .address_b(address_b), .read_data_b(read_data_b), .inflight(inflight)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
    logic [31:0] t;
    if (a == AW'(100)) return 24'hABCDEF;
    t = {15'b0, a} * 32'h9E3779B1;
    return t[30:7] ^ 24'h5A5A5A;
  endfunction

  function automatic bit is_sin(input logic [AW-1:0] a);
    return (a >= AW'(90000)) && (a < AW'(90300));
  endfunction

  // Memory stage port B: registered address in, registered data out.
  logic [AW-1:0] mem_a1 = '0;
  always @(posedge clk) begin
    mem_a1      <= address_b;
    read_data_b <= mem_f(mem_a1);
  end

  typedef struct {
    bit            owner;
    logic [DW-1:0] data;
    bit            err;
    int            due;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   n_vec = 0, n_miss = 0, cyc = 0, model_streak = 0, peak = 0;
  bit [2:0]      hist = '0;
  bit            e_disp, e_dbg;
  logic [AW-1:0] e_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor and reference model
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      sbq.delete();
      model_streak = 0;
      hist = '0;
    end else begin
      e_dbg  = dbg_req && (!disp_req || model_streak >= LIMIT);
      e_disp = disp_req && !e_dbg;
      e_addr = e_disp ? disp_addr : (e_dbg ? dbg_addr : '0);
      check("disp_gnt", 32'(disp_gnt), 32'(e_disp));
      check("dbg_gnt", 32'(dbg_gnt), 32'(e_dbg));
      check("address_b", 32'(address_b), 32'(e_addr));
      if (e_disp && dbg_req) model_streak = (model_streak < LIMIT) ? model_streak + 1 : LIMIT;
      else                   model_streak = 0;

      check("inflight", 32'(inflight), 32'(hist[0]) + 32'(hist[1]) + 32'(hist[2]));
      if (int'(inflight) > peak) peak = int'(inflight);

      while (sbq.size() > 0 && sbq[0].due < cyc) begin
        check("missing_return_due", 32'(cyc), 32'(sbq[0].due));
        void'(sbq.pop_front());
      end
      if (disp_valid || dbg_valid) begin
        check("one_valid", 32'(disp_valid && dbg_valid), 32'd0);
        if (sbq.size() == 0) begin
          check("spurious_valid", 32'(disp_valid || dbg_valid), 32'd0);
        end else begin
          e = sbq.pop_front();
          check("return_cycle", 32'(cyc), 32'(e.due));
          check("return_owner", 32'(dbg_valid), 32'(e.owner));
          if (dbg_valid) begin
            check("dbg_data", 32'(dbg_data), 32'(e.data));
            check("dbg_err", 32'(dbg_err), 32'(e.err));
          end else begin
            check("disp_data", 32'(disp_data), 32'(e.data));
          end
        end
      end

      if (e_disp || e_dbg)
        sbq.push_back('{owner: e_dbg,
                        data:  is_sin(e_addr) ? '0 : mem_f(e_addr),
                        err:   e_dbg && is_sin(e_addr),
                        due:   cyc + RL + 1});
      hist = {hist[1:0], e_disp || e_dbg};
    end
  end

  task automatic drive(input bit dr, input logic [AW-1:0] da, input bit br, input logic [AW-1:0] ba);
    @(posedge clk);
    #1;
    disp_req = dr; disp_addr = da; dbg_req = br; dbg_addr = ba;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, '0);
  endtask

  function automatic logic [AW-1:0] pick_addr();
    case ($urandom_range(0, 3))
      0:       return AW'($urandom_range(0, 131071));
      1:       return AW'($urandom_range(90000, 90299));
      2: begin
        case ($urandom_range(0, 3))
          0:       return AW'(89999);
          1:       return AW'(90000);
          2:       return AW'(90299);
          default: return AW'(90300);
        endcase
      end
      default: return AW'($urandom_range(90300, 131071));
    endcase
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_disp_gnt"},   32'(disp_gnt),   32'd0);
    check({tag, "_dbg_gnt"},    32'(dbg_gnt),    32'd0);
    check({tag, "_disp_valid"}, 32'(disp_valid), 32'd0);
    check({tag, "_dbg_valid"},  32'(dbg_valid),  32'd0);
    check({tag, "_disp_data"},  32'(disp_data),  32'd0);
    check({tag, "_dbg_data"},   32'(dbg_data),   32'd0);
    check({tag, "_dbg_err"},    32'(dbg_err),    32'd0);
    check({tag, "_address_b"},  32'(address_b),  32'd0);
    check({tag, "_inflight"},   32'(inflight),   32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    disp_req = 1'b0; disp_addr = '0; dbg_req = 1'b0; dbg_addr = '0;
    #12;
    check_all_zero("reset_state");
    #10 rst = 1'b0;

    // Single display read of address 100
    idle(3);
    drive(1'b1, AW'(100), 1'b0, '0);
    idle(5);

    // Sin window edges and first RAM address on the debug side
    drive(1'b0, '0, 1'b1, AW'(90000));
    drive(1'b0, '0, 1'b1, AW'(90299));
    drive(1'b0, '0, 1'b1, AW'(90300));
    idle(5);

    // Starvation guard: both requesting for 40 cycles
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, pick_addr(), 1'b1, pick_addr());
      @(negedge clk);
      #1;
      check("starve_dbg_gnt", 32'(dbg_gnt), 32'((i == 15) || (i == 31)));
    end
    idle(6);

    // Alternating single-cycle requests, back-to-back
    peak = 0;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) drive(1'b1, pick_addr(), 1'b0, '0);
      else            drive(1'b0, '0, 1'b1, pick_addr());
    end
    idle(6);
    check("interleave_peak", 32'(peak), 32'd3);

    // Idle drain
    idle(10);
    check("idle_inflight", 32'(inflight), 32'd0);

    // Asynchronous reset with three reads in flight
    for (int i = 0; i < 3; i++) drive(1'b1, pick_addr(), 1'b0, '0);
    @(posedge clk);
    #1;
    disp_req = 1'b0; dbg_req = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(8);
    check("post_reset_inflight", 32'(inflight), 32'd0);

    // Randomised traffic
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 3) != 0, pick_addr(), $urandom_range(0, 2) == 0, pick_addr());
    idle(8);
    check("queue_drained", 32'(sbq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
